// File: rtl/traffic_light_ctrl.sv
// Two-street traffic-light controller: A green/yellow, B green/yellow with one phase timer.
// Optional forced green timeout enabled by defining TRAFFIC_MAX_GREEN_EN.
module traffic_light_ctrl #(
  parameter int MIN_GREEN     = 8,
  parameter int YELLOW_CYCLES = 5,
  parameter int MAX_GREEN     = 32,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [1:0] state,
  output logic       phase_tick
);

  typedef enum logic [1:0] {S_AG = 2'd0, S_AY = 2'd1, S_BG = 2'd2, S_BY = 2'd3} state_e;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;

  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // Elaboration-time parameter sanity checks.
  if (MIN_GREEN < 1 || YELLOW_CYCLES < 1 || MAX_GREEN < MIN_GREEN) begin : g_bad_dur
    $error("traffic_light_ctrl: illegal duration parameters");
  end
  if (MAX_GREEN > (2**CNT_W) - 1 || MIN_GREEN > (2**CNT_W) - 1 ||
      YELLOW_CYCLES > (2**CNT_W) - 1) begin : g_bad_width
    $error("traffic_light_ctrl: CNT_W too narrow for durations");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             max_hit;

`ifdef TRAFFIC_MAX_GREEN_EN
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  assign max_hit = (cnt_q == MAX_LAST);
`else
  assign max_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_AG;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (enable) begin
      case (state_q)
        S_AG: if ((cnt_q >= GREEN_LAST && !ta) || max_hit) state_d = S_AY;
        S_AY: if (cnt_q == YEL_LAST) state_d = S_BG;
        S_BG: if ((cnt_q >= GREEN_LAST && !tb) || max_hit) state_d = S_BY;
        S_BY: if (cnt_q == YEL_LAST) state_d = S_AG;
        default: state_d = S_AG;
      endcase
      // Phase change restarts the timer; otherwise count up and stick at the top.
      if (state_d != state_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    la = L_RED;
    lb = L_RED;
    case (state_q)
      S_AG:    la = L_GREEN;
      S_AY:    la = L_YELLOW;
      S_BG:    lb = L_GREEN;
      S_BY:    lb = L_YELLOW;
      default: begin
        la = L_RED;
        lb = L_RED;
      end
    endcase
  end

  assign state      = state_q;
  assign phase_tick = tick_q;

endmodule
